max_min_tree_argidx: RTL and testbench



---
 rtl/max_min_tree_argidx.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_max_min_tree_argidx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_min_tree_argidx.sv
// ---------------------------------------------------------------------------
// max_min_tree_argidx
//
// Pipelined max/min reduction tree. It returns the winning operand and that
// operand's index for cmp_input_n operands on every beat. Each operand can be
// masked out. Max or min is chosen per beat. Pipeline registers are placed
// every reg_every tree levels.
//
// Optional feature macro: MAX_MIN_TREE_BEAT_ACC_EN
//   When this macro is defined, an accumulator stage follows the tree and
//   reduces all beats of a window (closed by cmp_in_last) into one result.
//   When it is undefined, every valid beat produces its own result.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   aclken         global clock enable; 0 freezes every register
//   cmp_in         operands, operand i at [(i+1)*cmp_width-1 : i*cmp_width]
//   cmp_in_mask    1 = operand participates
//   cmp_mode       0 = max, 1 = min, travels with its beat
//   cmp_in_last    last beat of a window (accumulating build only)
//   cmp_in_vld     beat valid
//   cmp_out        winning value (0 when nothing participated)
//   cmp_out_idx    operand index of the winner
//   cmp_out_none   no operand participated
//   cmp_out_vld    one-cycle result strobe
// ---------------------------------------------------------------------------
module max_min_tree_argidx #(
    parameter int cmp_input_n      = 9,
    parameter int cmp_width        = 8,
    parameter int signed_cmp       = 1,
    parameter int reg_every        = 2,
    parameter int simulation_delay = 1,
    localparam int IdxW = (cmp_input_n > 2) ? $clog2(cmp_input_n) : 1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             aclken,
    input  logic [cmp_input_n*cmp_width-1:0] cmp_in,
    input  logic [cmp_input_n-1:0]           cmp_in_mask,
    input  logic                             cmp_mode,
    input  logic                             cmp_in_last,
    input  logic                             cmp_in_vld,
    output logic [cmp_width-1:0]             cmp_out,
    output logic [IdxW-1:0]                  cmp_out_idx,
    output logic                             cmp_out_none,
    output logic                             cmp_out_vld
);

    localparam int Levels = $clog2(cmp_input_n);

    // Reject parameter values the tree cannot build.
    // simulation_delay is kept for interface compatibility with the older
    // fixed-size tree. The registers here are modelled without delay.
    if (cmp_input_n < 2 || cmp_input_n > 64) begin : g_badN
        $error("cmp_input_n must be in 2..64");
    end
    if (reg_every < 1 || reg_every > 6) begin : g_badRegEvery
        $error("reg_every must be in 1..6");
    end
    if (simulation_delay < 0) begin : g_badDelay
        $error("simulation_delay must be non-negative");
    end

    // Node count at a given level. An unpaired node is carried up, so the
    // count is halved with rounding up at each level.
    function automatic int nodesAt(input int lvl);
        int c;
        c = cmp_input_n;
        for (int k = 0; k < lvl; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Strict comparison: a beats b only if a is strictly better. Ties
    // therefore favour whichever side the caller passes as b.
    function automatic logic isBetter(input logic [cmp_width-1:0] a,
                                      input logic [cmp_width-1:0] b,
                                      input logic minMode);
        if (signed_cmp != 0) begin
            return minMode ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
        end
        return minMode ? (a < b) : (a > b);
    endfunction

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int Cnt = nodesAt(l);
        logic [cmp_width-1:0] levVal [Cnt];
        logic [IdxW-1:0]      levIdx [Cnt];
        logic                 levAny [Cnt];
        logic                 levVld;
        logic                 levMode;
        logic                 levLast;

        if (l == 0) begin : g_leaf
            // A masked operand becomes an all-zero invalid node. Invalid
            // nodes then stay zero all the way up the tree.
            for (genvar i = 0; i < Cnt; i++) begin : g_op
                assign levVal[i] = cmp_in_mask[i] ? cmp_in[i*cmp_width +: cmp_width] : '0;
                assign levIdx[i] = cmp_in_mask[i] ? IdxW'(i) : '0;
                assign levAny[i] = cmp_in_mask[i];
            end
            assign levVld  = cmp_in_vld;
            assign levMode = cmp_mode;
            assign levLast = cmp_in_last;
        end else begin : g_node
            localparam int PrevCnt = nodesAt(l - 1);
            logic [cmp_width-1:0] nodeVal_d [Cnt];
            logic [IdxW-1:0]      nodeIdx_d [Cnt];
            logic                 nodeAny_d [Cnt];

            for (genvar j = 0; j < Cnt; j++) begin : g_pair
                if (2*j + 1 < PrevCnt) begin : g_two
                    // The left child always covers lower operand indices.
                    // Only a strictly better right child displaces it, which
                    // gives lowest-index tie-breaking.
                    logic pickRight;
                    assign pickRight = g_lvl[l-1].levAny[2*j+1] &
                                       (~g_lvl[l-1].levAny[2*j] |
                                        isBetter(g_lvl[l-1].levVal[2*j+1],
                                                 g_lvl[l-1].levVal[2*j],
                                                 g_lvl[l-1].levMode));
                    assign nodeVal_d[j] = pickRight ? g_lvl[l-1].levVal[2*j+1] :
                                          (g_lvl[l-1].levAny[2*j] ? g_lvl[l-1].levVal[2*j] : '0);
                    assign nodeIdx_d[j] = pickRight ? g_lvl[l-1].levIdx[2*j+1] :
                                          (g_lvl[l-1].levAny[2*j] ? g_lvl[l-1].levIdx[2*j] : '0);
                    assign nodeAny_d[j] = g_lvl[l-1].levAny[2*j] | g_lvl[l-1].levAny[2*j+1];
                end else begin : g_one
                    assign nodeVal_d[j] = g_lvl[l-1].levVal[2*j];
                    assign nodeIdx_d[j] = g_lvl[l-1].levIdx[2*j];
                    assign nodeAny_d[j] = g_lvl[l-1].levAny[2*j];
                end
            end

            if ((l % reg_every == 0) || (l == Levels)) begin : g_reg
                logic [cmp_width-1:0] nodeVal_q [Cnt];
                logic [IdxW-1:0]      nodeIdx_q [Cnt];
                logic                 nodeAny_q [Cnt];
                logic                 vld_q;
                logic                 mode_q;
                logic                 last_q;

                // The data registers load only for a valid beat, so idle
                // cycles do not disturb the last result.
                always_ff @(posedge aclk or negedge aresetn) begin
                    if (!aresetn) begin
                        for (int k = 0; k < Cnt; k++) begin
                            nodeVal_q[k] <= '0;
                            nodeIdx_q[k] <= '0;
                            nodeAny_q[k] <= 1'b0;
                        end
                        mode_q <= 1'b0;
                        last_q <= 1'b0;
                    end else if (aclken && g_lvl[l-1].levVld) begin
                        for (int k = 0; k < Cnt; k++) begin
                            nodeVal_q[k] <= nodeVal_d[k];
                            nodeIdx_q[k] <= nodeIdx_d[k];
                            nodeAny_q[k] <= nodeAny_d[k];
                        end
                        mode_q <= g_lvl[l-1].levMode;
                        last_q <= g_lvl[l-1].levLast;
                    end
                end

                // The valid flag follows every enabled cycle, so each beat
                // gives exactly one pulse.
                always_ff @(posedge aclk or negedge aresetn) begin
                    if (!aresetn) begin
                        vld_q <= 1'b0;
                    end else if (aclken) begin
                        vld_q <= g_lvl[l-1].levVld;
                    end
                end

                assign levVal  = nodeVal_q;
                assign levIdx  = nodeIdx_q;
                assign levAny  = nodeAny_q;
                assign levVld  = vld_q;
                assign levMode = mode_q;
                assign levLast = last_q;
            end else begin : g_comb
                assign levVal  = nodeVal_d;
                assign levIdx  = nodeIdx_d;
                assign levAny  = nodeAny_d;
                assign levVld  = g_lvl[l-1].levVld;
                assign levMode = g_lvl[l-1].levMode;
                assign levLast = g_lvl[l-1].levLast;
            end
        end
    end

    logic [cmp_width-1:0] beatVal;
    logic [IdxW-1:0]      beatIdx;
    logic                 beatAny;
    logic                 beatVld;
    logic                 beatMode;
    logic                 beatLast;

    assign beatVal  = g_lvl[Levels].levVal[0];
    assign beatIdx  = g_lvl[Levels].levIdx[0];
    assign beatAny  = g_lvl[Levels].levAny[0];
    assign beatVld  = g_lvl[Levels].levVld;
    assign beatMode = g_lvl[Levels].levMode;
    assign beatLast = g_lvl[Levels].levLast;

`ifdef MAX_MIN_TREE_BEAT_ACC_EN
    logic                 inWindow_q;
    logic                 accMode_q;
    logic                 accAny_q;
    logic [cmp_width-1:0] accVal_q;
    logic [IdxW-1:0]      accIdx_q;
    logic [cmp_width-1:0] outVal_q;
    logic [IdxW-1:0]      outIdx_q;
    logic                 outNone_q;
    logic                 outVld_q;
    logic                 winMode;
    logic                 takeBeat;
    logic [cmp_width-1:0] accVal_d;
    logic [IdxW-1:0]      accIdx_d;
    logic                 accAny_d;

    // A beat outside a window starts a new one and loads the accumulator
    // directly. Within a window, the new beat must be strictly better to
    // win, so the earlier beat keeps a tie.
    always_comb begin
        winMode  = inWindow_q ? accMode_q : beatMode;
        takeBeat = beatAny & (~inWindow_q | ~accAny_q | isBetter(beatVal, accVal_q, winMode));
        accVal_d = '0;
        accIdx_d = '0;
        accAny_d = beatAny | (inWindow_q & accAny_q);
        if (takeBeat) begin
            accVal_d = beatVal;
            accIdx_d = beatIdx;
        end else if (inWindow_q && accAny_q) begin
            accVal_d = accVal_q;
            accIdx_d = accIdx_q;
        end
    end

    // The partial result lives in acc*_q. The out*_q registers are updated
    // only when a window closes, so the outputs hold between results.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inWindow_q <= 1'b0;
            accMode_q  <= 1'b0;
            accAny_q   <= 1'b0;
            accVal_q   <= '0;
            accIdx_q   <= '0;
            outVal_q   <= '0;
            outIdx_q   <= '0;
            outNone_q  <= 1'b0;
        end else if (aclken && beatVld) begin
            inWindow_q <= ~beatLast;
            accMode_q  <= winMode;
            accAny_q   <= accAny_d;
            accVal_q   <= accVal_d;
            accIdx_q   <= accIdx_d;
            if (beatLast) begin
                outVal_q  <= accVal_d;
                outIdx_q  <= accIdx_d;
                outNone_q <= ~accAny_d;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outVld_q <= 1'b0;
        end else if (aclken) begin
            outVld_q <= beatVld & beatLast;
        end
    end

    assign cmp_out      = outVal_q;
    assign cmp_out_idx  = outIdx_q;
    assign cmp_out_none = outNone_q;
    assign cmp_out_vld  = outVld_q;
`else
    logic resultSeen_q;
    logic unusedBeatBits;

    // The final tree registers reset to "nothing valid". This flag keeps
    // cmp_out_none low until the first real result arrives.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resultSeen_q <= 1'b0;
        end else if (aclken && beatVld) begin
            resultSeen_q <= 1'b1;
        end
    end

    assign unusedBeatBits = beatMode ^ beatLast;

    assign cmp_out      = beatAny ? beatVal : '0;
    assign cmp_out_idx  = beatAny ? beatIdx : '0;
    assign cmp_out_none = (resultSeen_q | beatVld) & ~beatAny;
    assign cmp_out_vld  = beatVld;
`endif

endmodule

// File: tb/tb_max_min_tree_argidx.sv
// ---------------------------------------------------------------------------
// tb_max_min_tree_argidx
//
// Drives a signed and an unsigned instance (9 x 8-bit, reg_every=2) with the
// same beats. Expected results go into one queue per instance when a beat is
// driven, and a monitor pops them when cmp_out_vld is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_max_min_tree_argidx;

    localparam int N  = 9;
    localparam int W  = 8;
    localparam int IW = 4;
`ifdef MAX_MIN_TREE_BEAT_ACC_EN
    localparam int P  = 3;
`else
    localparam int P  = 2;
`endif
    localparam int NumVec = 10;

    typedef struct {
        int         ops [N];
        logic [N-1:0] mask;
        logic       mode;
        int         expVal;
        int         expIdx;
        logic       expNone;
    } vec_t;

    typedef struct {
        logic [W-1:0]  val;
        logic [IW-1:0] idx;
        logic          none;
    } res_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken = 1'b0;
    logic [N*W-1:0] cmp_in = '0;
    logic [N-1:0]  cmp_in_mask = '0;
    logic          cmp_mode = 1'b0;
    logic          cmp_in_last = 1'b0;
    logic          cmp_in_vld = 1'b0;
    logic [W-1:0]  sOut, uOut;
    logic [IW-1:0] sIdx, uIdx;
    logic          sNone, uNone, sVld, uVld;

    vec_t vecs [NumVec];
    res_t sQ [$];
    res_t uQ [$];
    int   checks = 0;
    int   errors = 0;
    bit   monEn;

    max_min_tree_argidx #(.cmp_input_n(N), .cmp_width(W), .signed_cmp(1), .reg_every(2),
                          .simulation_delay(1)) dutS (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .cmp_in(cmp_in),
        .cmp_in_mask(cmp_in_mask), .cmp_mode(cmp_mode), .cmp_in_last(cmp_in_last),
        .cmp_in_vld(cmp_in_vld), .cmp_out(sOut), .cmp_out_idx(sIdx),
        .cmp_out_none(sNone), .cmp_out_vld(sVld));

    max_min_tree_argidx #(.cmp_input_n(N), .cmp_width(W), .signed_cmp(0), .reg_every(2),
                          .simulation_delay(1)) dutU (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .cmp_in(cmp_in),
        .cmp_in_mask(cmp_in_mask), .cmp_mode(cmp_mode), .cmp_in_last(cmp_in_last),
        .cmp_in_vld(cmp_in_vld), .cmp_out(uOut), .cmp_out_idx(uIdx),
        .cmp_out_none(uNone), .cmp_out_vld(uVld));

    // Free-running 100 MHz clock.
    always #5 aclk = ~aclk;

    // Hard stop in case something stalls forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic checkOutput(input string who, input res_t e, input logic [W-1:0] v,
                               input logic [IW-1:0] i, input logic n);
        checkVal({who, "_val"},  int'(v), int'(e.val));
        checkVal({who, "_idx"},  int'(i), int'(e.idx));
        checkVal({who, "_none"}, int'(n), int'(e.none));
    endtask

    // Reference reduction: a linear scan with a strict compare, so the
    // lowest-index operand keeps any tie.
    function automatic res_t model(input logic [N*W-1:0] ops, input logic [N-1:0] mask,
                                   input logic mode, input bit sgn);
        res_t r;
        bit found;
        bit better;
        logic [W-1:0] v;
        r = '{val: '0, idx: '0, none: 1'b1};
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                v = ops[i*W +: W];
                if (sgn) better = mode ? ($signed(v) < $signed(r.val)) : ($signed(v) > $signed(r.val));
                else     better = mode ? (v < r.val) : (v > r.val);
                if (!found || better) begin
                    r.val = v;
                    r.idx = IW'(i);
                    found = 1;
                end
            end
        end
        r.none = !found;
        return r;
    endfunction

    function automatic logic [N*W-1:0] packVec(input int vi);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(vecs[vi].ops[i]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] mkOps(input int base, input int pos, input int val);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = (i == pos) ? W'(val) : W'(base);
        return r;
    endfunction

    // Drive one beat on the falling edge so that it is stable at the rising edge.
    task automatic applyStimulus(input logic [N*W-1:0] ops, input logic [N-1:0] mask,
                                 input logic mode, input logic last);
        @(negedge aclk);
        cmp_in      = ops;
        cmp_in_mask = mask;
        cmp_mode    = mode;
        cmp_in_last = last;
        cmp_in_vld  = 1'b1;
    endtask

    task automatic applyVector(input int vi);
        res_t e;
        e.val  = W'(vecs[vi].expVal);
        e.idx  = IW'(vecs[vi].expIdx);
        e.none = vecs[vi].expNone;
        sQ.push_back(e);
        uQ.push_back(model(packVec(vi), vecs[vi].mask, vecs[vi].mode, 1'b0));
        applyStimulus(packVec(vi), vecs[vi].mask, vecs[vi].mode, 1'b1);
    endtask

    task automatic pushBoth(input int val, input int idx, input logic none);
        res_t e;
        e = '{val: W'(val), idx: IW'(idx), none: none};
        sQ.push_back(e);
        uQ.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && (sQ.size() != 0 || uQ.size() != 0); k++) @(negedge aclk);
        checkVal({tag, "_signed_pending"},   sQ.size(), 0);
        checkVal({tag, "_unsigned_pending"}, uQ.size(), 0);
    endtask

    // Monitor: a result counts once, on an enabled rising edge. A valid
    // frozen by aclken=0 is not consumed again.
    always @(posedge aclk) begin
        monEn = aclken && aresetn;
        #1;
        if (monEn && sVld) begin
            if (sQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL signed_extra_vld: got vld=1, expected no result pending");
            end else checkOutput("signed", sQ.pop_front(), sOut, sIdx, sNone);
        end
        if (monEn && uVld) begin
            if (uQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unsigned_extra_vld: got vld=1, expected no result pending");
            end else checkOutput("unsigned", uQ.pop_front(), uOut, uIdx, uNone);
        end
    end

    // Main sequence: reset, latency, table, stall, then optional windows.
    initial begin
        vecs[0] = '{'{3, -5, 7, 7, 0, 1, 2, -128, 6},           9'h1FF, 1'b0, 7, 2, 1'b0};
        vecs[1] = '{'{-100, 4, 9, 4, 20, 30, 40, 50, 60},        9'h1FE, 1'b1, 4, 1, 1'b0};
        vecs[2] = '{'{5, 5, 5, 5, 5, 5, 5, 5, 5},                9'h000, 1'b0, 0, 0, 1'b1};
        vecs[3] = '{'{-1, -2, -3, -4, -5, -6, -7, -8, -9},       9'h1FF, 1'b0, -1, 0, 1'b0};
        vecs[4] = '{'{-1, -2, -3, -4, -5, -6, -7, -8, -9},       9'h1FF, 1'b1, -9, 8, 1'b0};
        vecs[5] = '{'{100, 1, 2, 3, 4, 5, 6, 7, -3},             9'h100, 1'b0, -3, 8, 1'b0};
        vecs[6] = '{'{127, -128, 0, 0, 0, -128, 0, 0, 0},        9'h1FF, 1'b1, -128, 1, 1'b0};
        vecs[7] = '{'{0, 0, 0, 127, 0, 0, 0, 0, 127},            9'h1FF, 1'b0, 127, 3, 1'b0};
        vecs[8] = '{'{127, -128, 0, 0, 0, 0, 0, 0, 0},           9'h003, 1'b0, 127, 0, 1'b0};
        vecs[9] = '{'{0, 0, 0, 0, 50, -20, -20, 10, -90},        9'h0F0, 1'b1, -20, 5, 1'b0};

        aresetn = 1'b0;
        aclken  = 1'b1;
        repeat (3) @(negedge aclk);
        checkVal("reset_vld",  int'(sVld),  0);
        checkVal("reset_out",  int'(sOut),  0);
        checkVal("reset_idx",  int'(sIdx),  0);
        checkVal("reset_none", int'(sNone), 0);
        aresetn = 1'b1;

        // A single beat: the valid strobe must appear exactly P cycles later, for one cycle.
        applyVector(0);
        for (int k = 1; k <= P; k++) begin
            @(negedge aclk);
            cmp_in_vld = 1'b0;
            checkVal($sformatf("latency_vld_cycle%0d", k), int'(sVld), (k == P) ? 1 : 0);
        end
        @(negedge aclk);
        checkVal("vld_single_pulse", int'(sVld), 0);
        drain("latency");

        // Back-to-back table beats with alternating modes.
        for (int v = 0; v < NumVec; v++) applyVector(v);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        drain("table");

        // max/min/max back-to-back, then three stalled cycles. The outputs
        // must hold whichever result is on them when the stall starts.
        applyVector(0);
        applyVector(1);
        applyVector(3);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        aclken     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            checkVal($sformatf("stall%0d_out", k), int'(sOut), (P == 2) ? 4 : 7);
            checkVal($sformatf("stall%0d_idx", k), int'(sIdx), (P == 2) ? 1 : 2);
            checkVal($sformatf("stall%0d_vld", k), int'(sVld), 1);
        end
        aclken = 1'b1;
        drain("stall");

`ifdef MAX_MIN_TREE_BEAT_ACC_EN
        // A 3-beat max window with maxima 5, 9, 9: the earlier 9 (beat 2, idx 4) wins.
        applyStimulus(mkOps(1, 0, 5), 9'h1FF, 1'b0, 1'b0);
        applyStimulus(mkOps(2, 4, 9), 9'h1FF, 1'b0, 1'b0);
        pushBoth(9, 4, 1'b0);
        applyStimulus(mkOps(3, 6, 9), 9'h1FF, 1'b0, 1'b1);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        drain("window_max");

        // A min window whose tie across beats must keep the first beat's index.
        applyStimulus(mkOps(50, 3, 4), 9'h1FF, 1'b1, 1'b0);
        pushBoth(4, 3, 1'b0);
        applyStimulus(mkOps(50, 1, 4), 9'h1FF, 1'b1, 1'b1);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        drain("window_min_tie");

        // Reset in the middle of a window: the partial 100 must not leak into the next window.
        applyStimulus(mkOps(0, 0, 100), 9'h1FF, 1'b0, 1'b0);
        applyStimulus(mkOps(0, 1, 100), 9'h1FF, 1'b0, 1'b0);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        repeat (4) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        checkVal("midreset_vld", int'(sVld), 0);
        checkVal("midreset_out", int'(sOut), 0);
        aresetn = 1'b1;
        pushBoth(3, 2, 1'b0);
        applyStimulus(mkOps(0, 2, 3), 9'h1FF, 1'b0, 1'b1);
        @(negedge aclk);
        cmp_in_vld = 1'b0;
        drain("after_reset");
`endif

        repeat (5) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
